mem_bus_master: RTL
===================

Name: mem_bus_master

Overview:
- Initiator side of the 16x8 asynchronous memory interface (4-bit address, read/write strobes, 8-bit data in/out).
- Accepts single read or write requests from the CPU control path over a valid/ready handshake.
- Sequences the memory strobes with stable address/data setup and returns read data with a one-cycle response pulse.
- Sits between the CPU fetch/execute control and the memory block; guarantees strobes are never glitchy or overlapping.

Parameters:
ADDR_W, 4, memory address width
DATA_W, 8, memory data width
WAIT_CYCLES, 1, cycles the read/write strobe is held high; values below 1 behave as 1

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous reset, active-high
req_valid  input  1  CPU request present
req_ready  output  1  block can accept a request (high only in IDLE)
req_write  input  1  1 = write, 0 = read
req_addr  input  ADDR_W  request address
req_wdata  input  DATA_W  write data
rsp_valid  output  1  one-cycle pulse: transaction complete (read or write)
rsp_rdata  output  DATA_W  captured read data, held until next read completes
busy  output  1  high in any state other than IDLE
mem_address  output  ADDR_W  to memory address
mem_read  output  1  to memory read strobe
mem_write  output  1  to memory write strobe
mem_data_in  output  DATA_W  to memory write data
mem_data_out  input  DATA_W  from memory read data

Behaviour:
- Reset values: state IDLE; rsp_valid=0, rsp_rdata=0, mem_address=0, mem_read=0, mem_write=0, mem_data_in=0, busy=0, req_ready=1. The reset value applies from the first edge where rst=1.
- req_ready is decoded from state (IDLE); all other outputs are registered.
- Accept: on an edge with state=IDLE, req_valid=1, rst=0.
  - Latch req_write, req_addr and req_wdata.
  - Go to SETUP.
  - Inputs are ignored after acceptance.
- SETUP (1 cycle):
  - mem_address = latched addr.
  - mem_data_in = latched wdata for writes, unchanged for reads.
  - Both strobes are 0.
  - Next state STROBE; wait counter loaded with WAIT_CYCLES.
- STROBE (WAIT_CYCLES cycles):
  - Exactly one of mem_read/mem_write is 1, per the latched req_write.
  - Address and data are held stable.
  - The counter decrements each cycle.
  - On the edge ending the last STROBE cycle:
    - For reads, capture mem_data_out into rsp_rdata.
    - Go to DONE.
- DONE (1 cycle):
  - Strobes are 0; rsp_valid=1; address and data are held.
  - Next state IDLE.
  - rsp_rdata is unchanged by writes.
- Latency: with the accept edge as edge 0, rsp_valid is high in cycle WAIT_CYCLES+2. Example: WAIT_CYCLES=1 gives SETUP in cycle 1, STROBE in cycle 2, DONE in cycle 3.
- Throughput: at most one transaction per WAIT_CYCLES+3 cycles. req_ready is low from SETUP through DONE.
- Invariants:
  - mem_read & mem_write is never 1.
  - Strobes never rise in the same cycle that mem_address changes.
  - rsp_valid never lasts more than 1 cycle.
- Reset mid-transaction (any state): the transaction is abandoned and everything returns to reset values at that edge. No rsp_valid is issued for the aborted request. req_valid is ignored while rst=1.
- Counter width: ceil(log2(WAIT_CYCLES+1)) bits, minimum 1; no wrap-around reachable.

Test Plan:
1. Reset check: rst=1 for 2 cycles, then 0 -> all outputs at reset values, req_ready=1, busy=0, no strobes.
2. Read, WAIT_CYCLES=1, req_addr=0x0, memory power-up image (addr 0 = 0x4C):
   - cycle 1: mem_address=0, strobes 0.
   - cycle 2: mem_read=1.
   - cycle 3: rsp_valid=1, rsp_rdata=0x4C, mem_read=0.
3. Write 0xA5 to addr 0x3, then read 0x3:
   - mem_write is high exactly 1 cycle, with mem_data_in=0xA5 stable from SETUP.
   - rsp_valid pulses and rsp_rdata is unchanged.
   - The following read returns rsp_rdata=0xA5.
4. WAIT_CYCLES=3, read addr 0xB (image value 0xE0) -> mem_read high 3 consecutive cycles, rsp_valid in cycle 5 after accept, rsp_rdata=0xE0.
5. req_valid held high with req_addr/req_wdata changing every cycle -> accepts only when req_ready=1, one transaction per 4 cycles (WAIT_CYCLES=1), each using the values present at its accept edge.
6. rst asserted during STROBE of a write to addr 0x5 -> at that edge mem_write=0, busy=0, req_ready=1; no rsp_valid; the next request is accepted normally.

Source files
------------

// File: rtl/mem_bus_master_if.sv
// Request/response and memory-strobe bundle between CPU control, mem_bus_master and memory.
// master modport is the bus-master side; slave modport is the CPU/memory side.
interface mem_bus_master_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic              mem_write;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, mem_data_out,
        output req_ready, rsp_valid, rsp_rdata, busy,
               mem_address, mem_read, mem_write, mem_data_in
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, mem_data_out,
        input  req_ready, rsp_valid, rsp_rdata, busy,
               mem_address, mem_read, mem_write, mem_data_in
    );
endinterface

// File: rtl/mem_bus_master.sv
// Async-memory initiator: one read/write per request, rsp_valid pulse WAIT_CYCLES+2 cycles after accept.
// Backpressure: req_ready high only in IDLE; requests are held off for the whole SETUP/STROBE/DONE sequence.
module mem_bus_master #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    mem_bus_master_if.master      bus
);
    localparam int WEFF  = (WAIT_CYCLES < 1) ? 1 : WAIT_CYCLES;
    localparam int CNT_W = ($clog2(WEFF + 1) < 1) ? 1 : $clog2(WEFF + 1);

    typedef enum logic [1:0] {IDLE, SETUP, STROBE, DONE} state_t;

    state_t            state_q, state_d;
    logic              write_q, write_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic              busy_q, busy_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            write_q     <= 1'b0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 1'b0;
            wr_q        <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            write_q     <= write_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            busy_q      <= busy_d;
        end
    end

    // Strobes are registered one state ahead so they only rise after the address has settled in SETUP.
    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rd_d        = 1'b0;
        wr_d        = 1'b0;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    state_d = SETUP;
                    write_d = bus.req_write;
                    addr_d  = bus.req_addr;
                    busy_d  = 1'b1;
                    if (bus.req_write) begin
                        wdata_d = bus.req_wdata;
                    end
                end
            end
            SETUP: begin
                state_d = STROBE;
                cnt_d   = CNT_W'(WEFF);
                rd_d    = !write_q;
                wr_d    = write_q;
            end
            STROBE: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d     = DONE;
                    rsp_valid_d = 1'b1;
                    if (!write_q) begin
                        rsp_rdata_d = bus.mem_data_out;
                    end
                end else begin
                    rd_d = !write_q;
                    wr_d = write_q;
                end
            end
            DONE: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign bus.req_ready   = (state_q == IDLE);
    assign bus.rsp_valid   = rsp_valid_q;
    assign bus.rsp_rdata   = rsp_rdata_q;
    assign bus.busy        = busy_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_read    = rd_q;
    assign bus.mem_write   = wr_q;
    assign bus.mem_data_in = wdata_q;
endmodule
